// File: rtl/x86_byte_decoder.sv
// Byte-serial x86-64 instruction length/field decoder. Walks prefixes, REX, opcode, ModRM,
// SIB, displacement and immediate; presents one record per instruction via valid/ready.
module x86_byte_decoder #(
    parameter int unsigned MAX_LEN = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic [7:0]  o_info_idx,
    input  logic [23:0] i_info_word,
    output logic        o_dec_valid,
    input  logic        i_dec_ready,
    output logic [3:0]  o_dec_len,
    output logic [5:0]  o_dec_pfx,
    output logic [3:0]  o_dec_rex,
    output logic [7:0]  o_dec_opcode,
    output logic [23:0] o_dec_info,
    output logic [7:0]  o_dec_modrm,
    output logic [7:0]  o_dec_sib,
    output logic [31:0] o_dec_disp,
    output logic [63:0] o_dec_imm,
    output logic        o_dec_invalid
);

    typedef enum logic [2:0] {StPrefix, StModrm, StSib, StDisp, StImm, StEmit} state_t;

    state_t      r_state, w_state_d;
    logic [3:0]  r_cnt, w_cnt_d;
    logic [5:0]  r_pfx, w_pfx_d;
    logic [3:0]  r_rex, w_rex_d;
    logic [7:0]  r_opcode, w_opcode_d;
    logic [23:0] r_info, w_info_d;
    logic [7:0]  r_modrm, w_modrm_d;
    logic [7:0]  r_sib, w_sib_d;
    logic [31:0] r_disp, w_disp_d;
    logic [63:0] r_imm, w_imm_d;
    logic        r_invalid, w_invalid_d;
    logic [2:0]  r_disp_need, w_disp_need_d;
    logic [3:0]  r_imm_need, w_imm_need_d;
    logic [2:0]  r_sub, w_sub_d;

    logic        w_accept;
    logic [3:0]  w_cnt_inc;
    logic [3:0]  w_sub_inc;
    logic [3:0]  w_imm_bytes;
    logic        w_need_modrm;
    logic [7:0]  w_b;

    assign w_b          = i_byte_data;
    assign o_info_idx   = i_byte_data;
    assign o_byte_ready = (r_state != StEmit);
    assign o_dec_valid  = (r_state == StEmit);
    assign w_accept     = i_byte_valid && o_byte_ready;
    assign w_cnt_inc    = r_cnt + 4'd1;
    assign w_sub_inc    = {1'b0, r_sub} + 4'd1;

    // Operand decode on the live table entry; only operands below numop count.
    always_comb begin
        logic [1:0] w_sz;
        logic       w_has_imm;
        w_sz         = 2'b00;
        w_has_imm    = 1'b0;
        w_need_modrm = 1'b0;
        w_imm_bytes  = 4'd0;
        if (i_info_word[22:21] >= 2'd1) begin
            if (!i_info_word[20]) w_need_modrm = 1'b1;
            if (i_info_word[20:19] == 2'b10) begin
                w_has_imm = 1'b1;
                w_sz      = i_info_word[16:15];
            end
        end
        if (i_info_word[22:21] >= 2'd2) begin
            if (!i_info_word[18]) w_need_modrm = 1'b1;
            if (!w_has_imm && i_info_word[18:17] == 2'b10) begin
                w_has_imm = 1'b1;
                w_sz      = i_info_word[14:13];
            end
        end
        if (w_has_imm) begin
            case (w_sz)
                2'b00:   w_imm_bytes = 4'd1;
                2'b01:   w_imm_bytes = 4'd2;
                2'b10:   w_imm_bytes = r_pfx[4] ? 4'd2 : 4'd4;
                default: w_imm_bytes = r_rex[3] ? 4'd8 : 4'd4;
            endcase
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_pfx_d       = r_pfx;
        w_rex_d       = r_rex;
        w_opcode_d    = r_opcode;
        w_info_d      = r_info;
        w_modrm_d     = r_modrm;
        w_sib_d       = r_sib;
        w_disp_d      = r_disp;
        w_imm_d       = r_imm;
        w_invalid_d   = r_invalid;
        w_disp_need_d = r_disp_need;
        w_imm_need_d  = r_imm_need;
        w_sub_d       = r_sub;

        case (r_state)
            StPrefix: if (w_accept) begin
                w_cnt_d = w_cnt_inc;
                case (w_b)
                    8'h66: begin w_pfx_d[4] = 1'b1; w_rex_d = 4'd0; end
                    8'h67: begin w_pfx_d[3] = 1'b1; w_rex_d = 4'd0; end
                    8'hF0: begin w_pfx_d[2] = 1'b1; w_rex_d = 4'd0; end
                    8'hF2: begin w_pfx_d[1] = 1'b1; w_rex_d = 4'd0; end
                    8'hF3: begin w_pfx_d[0] = 1'b1; w_rex_d = 4'd0; end
                    8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: begin
                        w_pfx_d[5] = 1'b1;
                        w_rex_d    = 4'd0;
                    end
                    8'h0F: begin
                        w_opcode_d  = w_b;
                        w_invalid_d = 1'b1;
                        w_state_d   = StEmit;
                    end
                    default: begin
                        if (w_b[7:4] == 4'h4) begin
                            w_rex_d = w_b[3:0];
                        end else begin
                            w_opcode_d   = w_b;
                            w_info_d     = i_info_word;
                            w_imm_need_d = w_imm_bytes;
                            if (i_info_word == 24'd0) begin
                                w_invalid_d = 1'b1;
                                w_state_d   = StEmit;
                            end else if (w_need_modrm) w_state_d = StModrm;
                            else if (w_imm_bytes != 4'd0) w_state_d = StImm;
                            else w_state_d = StEmit;
                        end
                    end
                endcase
            end
            StModrm: if (w_accept) begin
                w_cnt_d   = w_cnt_inc;
                w_modrm_d = w_b;
                if (w_b[7:6] == 2'b01) w_disp_need_d = 3'd1;
                else if (w_b[7:6] == 2'b10) w_disp_need_d = 3'd4;
                else if (w_b[7:6] == 2'b00 && w_b[2:0] == 3'b101) w_disp_need_d = 3'd4;
                else w_disp_need_d = 3'd0;
                if (w_b[7:6] != 2'b11 && w_b[2:0] == 3'b100) w_state_d = StSib;
                else if (w_disp_need_d != 3'd0) w_state_d = StDisp;
                else if (r_imm_need != 4'd0) w_state_d = StImm;
                else w_state_d = StEmit;
            end
            StSib: if (w_accept) begin
                w_cnt_d = w_cnt_inc;
                w_sib_d = w_b;
                if (r_modrm[7:6] == 2'b00 && w_b[2:0] == 3'b101) w_disp_need_d = 3'd4;
                if (w_disp_need_d != 3'd0) w_state_d = StDisp;
                else if (r_imm_need != 4'd0) w_state_d = StImm;
                else w_state_d = StEmit;
            end
            StDisp: if (w_accept) begin
                w_cnt_d = w_cnt_inc;
                w_disp_d[{r_sub[1:0], 3'b000} +: 8] = w_b;
                if (w_sub_inc == {1'b0, r_disp_need}) begin
                    if (r_disp_need == 3'd1) w_disp_d = {{24{w_b[7]}}, w_b};
                    w_sub_d   = 3'd0;
                    w_state_d = (r_imm_need != 4'd0) ? StImm : StEmit;
                end else begin
                    w_sub_d = w_sub_inc[2:0];
                end
            end
            StImm: if (w_accept) begin
                w_cnt_d = w_cnt_inc;
                w_imm_d[{r_sub, 3'b000} +: 8] = w_b;
                if (w_sub_inc == r_imm_need) begin
                    w_sub_d   = 3'd0;
                    w_state_d = StEmit;
                end else begin
                    w_sub_d = w_sub_inc[2:0];
                end
            end
            StEmit: if (i_dec_ready) begin
                w_state_d     = StPrefix;
                w_cnt_d       = 4'd0;
                w_pfx_d       = 6'd0;
                w_rex_d       = 4'd0;
                w_opcode_d    = 8'd0;
                w_info_d      = 24'd0;
                w_modrm_d     = 8'd0;
                w_sib_d       = 8'd0;
                w_disp_d      = 32'd0;
                w_imm_d       = 64'd0;
                w_invalid_d   = 1'b0;
                w_disp_need_d = 3'd0;
                w_imm_need_d  = 4'd0;
                w_sub_d       = 3'd0;
            end
            default: w_state_d = StPrefix;
        endcase

        // Ran out of legal length before the instruction closed.
        if (w_accept && w_cnt_inc == 4'(MAX_LEN) && w_state_d != StEmit) begin
            w_state_d   = StEmit;
            w_invalid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_state     <= StPrefix;
            r_cnt       <= 4'd0;
            r_pfx       <= 6'd0;
            r_rex       <= 4'd0;
            r_opcode    <= 8'd0;
            r_info      <= 24'd0;
            r_modrm     <= 8'd0;
            r_sib       <= 8'd0;
            r_disp      <= 32'd0;
            r_imm       <= 64'd0;
            r_invalid   <= 1'b0;
            r_disp_need <= 3'd0;
            r_imm_need  <= 4'd0;
            r_sub       <= 3'd0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_pfx       <= w_pfx_d;
            r_rex       <= w_rex_d;
            r_opcode    <= w_opcode_d;
            r_info      <= w_info_d;
            r_modrm     <= w_modrm_d;
            r_sib       <= w_sib_d;
            r_disp      <= w_disp_d;
            r_imm       <= w_imm_d;
            r_invalid   <= w_invalid_d;
            r_disp_need <= w_disp_need_d;
            r_imm_need  <= w_imm_need_d;
            r_sub       <= w_sub_d;
        end
    end

    assign o_dec_len     = r_cnt;
    assign o_dec_pfx     = r_pfx;
    assign o_dec_rex     = r_rex;
    assign o_dec_opcode  = r_opcode;
    assign o_dec_info    = r_info;
    assign o_dec_modrm   = r_modrm;
    assign o_dec_sib     = r_sib;
    assign o_dec_disp    = r_disp;
    assign o_dec_imm     = r_imm;
    assign o_dec_invalid = r_invalid;

endmodule

// File: tb/tb_x86_byte_decoder.sv
// Directed bench for x86_byte_decoder with a small hand-built opcode info table.
module tb_x86_byte_decoder;

    logic        i_clk = 1'b0;
    logic        i_reset, i_flush, i_byte_valid, i_dec_ready;
    logic [7:0]  i_byte_data;
    logic [23:0] i_info_word;
    logic        o_byte_ready, o_dec_valid, o_dec_invalid;
    logic [7:0]  o_info_idx, o_dec_opcode, o_dec_modrm, o_dec_sib;
    logic [3:0]  o_dec_len, o_dec_rex;
    logic [5:0]  o_dec_pfx;
    logic [23:0] o_dec_info;
    logic [31:0] o_dec_disp;
    logic [63:0] o_dec_imm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    x86_byte_decoder #(.MAX_LEN(15)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data), .o_byte_ready(o_byte_ready),
        .o_info_idx(o_info_idx), .i_info_word(i_info_word),
        .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready), .o_dec_len(o_dec_len),
        .o_dec_pfx(o_dec_pfx), .o_dec_rex(o_dec_rex), .o_dec_opcode(o_dec_opcode),
        .o_dec_info(o_dec_info), .o_dec_modrm(o_dec_modrm), .o_dec_sib(o_dec_sib),
        .o_dec_disp(o_dec_disp), .o_dec_imm(o_dec_imm), .o_dec_invalid(o_dec_invalid)
    );

    // Hand-encoded table entries: numop, kinds, sizes, group.
    always_comb begin
        i_info_word = 24'd0;
        case (o_info_idx)
            8'h01: i_info_word = 24'h494001; // r/m32, reg32
            8'h05: i_info_word = 24'h5D4001; // eAX, imm32
            8'h89: i_info_word = 24'h494002; // r/m, reg
            8'h8B: i_info_word = 24'h434002; // reg, r/m
            8'hB8: i_info_word = 24'h5DE002; // rAX, imm64 with REX.W
            8'h90: i_info_word = 24'h000003; // no operands
            default: i_info_word = 24'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        @(posedge i_clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_rec(input string tag);
        int n = 0;
        while (o_dec_valid !== 1'b1 && n < 20) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk({tag, "_valid"}, {63'd0, o_dec_valid}, 64'd1);
    endtask

    task automatic chk_rec(input string tag, input logic [3:0] len, input logic [5:0] pfx,
                           input logic [3:0] rex, input logic [7:0] opc, input logic [7:0] modrm,
                           input logic [7:0] sib, input logic [31:0] disp,
                           input logic [63:0] imm, input logic inv);
        wait_rec(tag);
        chk({tag, "_len"},   {60'd0, o_dec_len}, {60'd0, len});
        chk({tag, "_pfx"},   {58'd0, o_dec_pfx}, {58'd0, pfx});
        chk({tag, "_rex"},   {60'd0, o_dec_rex}, {60'd0, rex});
        chk({tag, "_opc"},   {56'd0, o_dec_opcode}, {56'd0, opc});
        chk({tag, "_modrm"}, {56'd0, o_dec_modrm}, {56'd0, modrm});
        chk({tag, "_sib"},   {56'd0, o_dec_sib}, {56'd0, sib});
        chk({tag, "_disp"},  {32'd0, o_dec_disp}, {32'd0, disp});
        chk({tag, "_imm"},   o_dec_imm, imm);
        chk({tag, "_inv"},   {63'd0, o_dec_invalid}, {63'd0, inv});
    endtask

    task automatic consume();
        i_dec_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_dec_ready = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_flush = 1'b0; i_byte_valid = 1'b0; i_byte_data = 8'd0;
        i_dec_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        chk("rst_valid", {63'd0, o_dec_valid}, 64'd0);
        chk("rst_bready", {63'd0, o_byte_ready}, 64'd1);
        chk("rst_len", {60'd0, o_dec_len}, 64'd0);
        chk("rst_imm", o_dec_imm, 64'd0);

        // REX.W add eax, imm32
        send(8'h48); send(8'h05); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk_rec("add_imm", 4'd6, 6'h00, 4'h8, 8'h05, 8'h00, 8'h00, 32'd0, 64'h12345678, 1'b0);
        chk("add_info", {40'd0, o_dec_info}, 64'h5D4001);
        consume();

        // Operand-size prefix shrinks imm32 to imm16
        send(8'h66); send(8'h05); send(8'h34); send(8'h12);
        chk_rec("add_imm16", 4'd4, 6'h10, 4'h0, 8'h05, 8'h00, 8'h00, 32'd0, 64'h1234, 1'b0);
        consume();

        // Register-direct ModRM, then a held record
        send(8'h01); send(8'hD8);
        chk_rec("add_rr", 4'd2, 6'h00, 4'h0, 8'h01, 8'hD8, 8'h00, 32'd0, 64'd0, 1'b0);
        i_byte_valid = 1'b1;
        i_byte_data  = 8'h90;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            chk("hold_valid", {63'd0, o_dec_valid}, 64'd1);
            chk("hold_bready", {63'd0, o_byte_ready}, 64'd0);
            chk("hold_modrm", {56'd0, o_dec_modrm}, 64'hD8);
            chk("hold_len", {60'd0, o_dec_len}, 64'd2);
        end
        i_dec_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_dec_ready  = 1'b0;
        i_byte_valid = 1'b0;
        chk("rel_valid", {63'd0, o_dec_valid}, 64'd0);
        chk("rel_bready", {63'd0, o_byte_ready}, 64'd1);
        chk("rel_len", {60'd0, o_dec_len}, 64'd0);

        // ModRM + SIB + disp8
        send(8'h48); send(8'h89); send(8'h44); send(8'h24); send(8'hF8);
        chk_rec("mov_sib", 4'd5, 6'h00, 4'h8, 8'h89, 8'h44, 8'h24, 32'hFFFFFFF8, 64'd0, 1'b0);
        consume();

        // RIP-relative disp32
        send(8'h8B); send(8'h05); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk_rec("mov_rip", 4'd6, 6'h00, 4'h0, 8'h8B, 8'h05, 8'h00, 32'h44332211, 64'd0, 1'b0);
        consume();

        // SIB with no base: disp32 chosen in SIB
        send(8'h8B); send(8'h04); send(8'h25);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk_rec("mov_abs", 4'd7, 6'h00, 4'h0, 8'h8B, 8'h04, 8'h25, 32'h12345678, 64'd0, 1'b0);
        consume();

        // movabs rax, imm64
        send(8'h48); send(8'hB8);
        send(8'hEF); send(8'hCD); send(8'hAB); send(8'h89);
        send(8'h67); send(8'h45); send(8'h23); send(8'h01);
        chk_rec("movabs", 4'd10, 6'h00, 4'h8, 8'hB8, 8'h00, 8'h00, 32'd0,
                64'h0123456789ABCDEF, 1'b0);
        consume();

        // Empty table entry
        send(8'h06);
        chk_rec("inv_06", 4'd1, 6'h00, 4'h0, 8'h06, 8'h00, 8'h00, 32'd0, 64'd0, 1'b1);
        consume();

        // Two-byte escape not supported
        send(8'h0F);
        chk_rec("inv_0f", 4'd1, 6'h00, 4'h0, 8'h0F, 8'h00, 8'h00, 32'd0, 64'd0, 1'b1);
        consume();

        // Length guard
        for (int i = 0; i < 15; i++) send(8'h66);
        chk_rec("too_long", 4'd15, 6'h10, 4'h0, 8'h00, 8'h00, 8'h00, 32'd0, 64'd0, 1'b1);
        consume();

        // Flush in the middle of a displacement
        send(8'h8B); send(8'h80); send(8'h11);
        i_flush      = 1'b1;
        i_byte_valid = 1'b1;
        i_byte_data  = 8'h22;
        @(posedge i_clk);
        #1;
        i_flush      = 1'b0;
        i_byte_valid = 1'b0;
        chk("flush_valid", {63'd0, o_dec_valid}, 64'd0);
        chk("flush_len", {60'd0, o_dec_len}, 64'd0);
        chk("flush_opc", {56'd0, o_dec_opcode}, 64'd0);
        send(8'h90);
        chk_rec("nop", 4'd1, 6'h00, 4'h0, 8'h90, 8'h00, 8'h00, 32'd0, 64'd0, 1'b0);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
